// File: rtl/msk_scan_pkg.sv
// rtl/msk_scan_pkg.sv - shared FSM encoding and counter sizing for the masked scan chain
package msk_scan_pkg;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_DONE  = S_DONE
  } scan_state_e;

  // Shift counter width; a one-stage chain still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msk_scan_stage.sv
// rtl/msk_scan_stage.sv - one masked scan stage: hold / parallel / shift select into an enable register
module msk_scan_stage #(
  parameter int d     = 2,
  parameter int count = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic               shift_en,
  input  logic [count*d-1:0] par_in,
  input  logic [count*d-1:0] shift_in,
  output logic [count*d-1:0] q
);

  logic [count*d-1:0] next_q;

  // Whole-word select; shares are only routed, never combined, so bit i*d+j stays share j of bit i.
  always_comb begin
    next_q = q;
    if (load_en) begin
      next_q = par_in;
    end else if (shift_en) begin
      next_q = shift_in;
    end
  end

  // Stage register; reset to all-zero shares, which is a valid sharing of zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load_en || shift_en) begin
      q <= next_q;
    end
  end

endmodule

// File: rtl/msk_scan_chain.sv
// rtl/msk_scan_chain.sv - counted, handshaked masked scan chain with open and circular scan
module msk_scan_chain
  import msk_scan_pkg::*;
#(
  parameter int d     = 2,
  parameter int count = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [depth*count*d-1:0] in_par,
  input  logic                     scan_start,
  input  logic                     rotate,
  input  logic [count*d-1:0]       scan_in,
  output logic [count*d-1:0]       scan_out,
  output logic [depth*count*d-1:0] out_par,
  output logic                     busy,
  output logic                     done
);

  localparam int W  = count * d;
  localparam int CW = cnt_width(depth);
  localparam logic [CW-1:0] LAST = CW'(depth - 1);

  scan_state_e   state;
  logic [CW-1:0] cnt;
  logic          rot_q;
  logic          load_acc;
  logic          shift_en;
  logic [W-1:0]  stage_q   [depth];
  logic [W-1:0]  shift_src [depth];

  assign load_acc = load_valid & load_ready;
  assign shift_en = (state == ST_SHIFT);

  // Scan sequencer; busy/done/load_ready are registered from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      rot_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (!load_acc && scan_start) begin
            state      <= ST_SHIFT;
            rot_q      <= rotate;
            cnt        <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            load_ready <= 1'b0;
          end else begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state      <= ST_DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
            load_ready <= 1'b1;
          end
        end
        default: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          done       <= 1'b0;
          load_ready <= 1'b1;
        end
      endcase
    end
  end

  // Stage 0 takes the external word or the wrapped last stage; others take their predecessor.
  assign shift_src[0] = rot_q ? stage_q[depth-1] : scan_in;

  for (genvar k = 0; k < depth; k++) begin : g_stage
    if (k > 0) begin : g_link
      assign shift_src[k] = stage_q[k-1];
    end

    (* keep_hierarchy = "yes" *)
    msk_scan_stage #(
      .d     (d),
      .count (count)
    ) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .load_en  (load_acc),
      .shift_en (shift_en),
      .par_in   (in_par[k*W +: W]),
      .shift_in (shift_src[k]),
      .q        (stage_q[k])
    );

    assign out_par[k*W +: W] = stage_q[k];
  end

  assign scan_out = stage_q[depth-1];

endmodule

// File: tb/tb_msk_scan_chain.sv
// tb/tb_msk_scan_chain.sv - directed table-driven bench for msk_scan_chain
module tb_msk_scan_chain;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        load_valid, load_ready, scan_start, rotate, busy, done;
  logic [63:0] in_par, out_par;
  logic [15:0] scan_in, scan_out;

  logic        u1_load_valid, u1_load_ready, u1_scan_start, u1_rotate, u1_busy, u1_done;
  logic [15:0] u1_in_par, u1_out_par, u1_scan_in, u1_scan_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        lv;
    logic [63:0] ip;
    logic        ss;
    logic        rot;
    logic [15:0] si;
    logic [63:0] eo;
    logic [15:0] es;
    logic        eb;
    logic        ed;
    logic        er;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  msk_scan_chain #(.d(2), .count(8), .depth(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .in_par     (in_par),
    .scan_start (scan_start),
    .rotate     (rotate),
    .scan_in    (scan_in),
    .scan_out   (scan_out),
    .out_par    (out_par),
    .busy       (busy),
    .done       (done)
  );

  msk_scan_chain #(.d(2), .count(8), .depth(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (u1_load_valid),
    .load_ready (u1_load_ready),
    .in_par     (u1_in_par),
    .scan_start (u1_scan_start),
    .rotate     (u1_rotate),
    .scan_in    (u1_scan_in),
    .scan_out   (u1_scan_out),
    .out_par    (u1_out_par),
    .busy       (u1_busy),
    .done       (u1_done)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic lv, input logic [63:0] ip, input logic ss, input logic rot,
                     input logic [15:0] si, input logic [63:0] eo, input logic [15:0] es,
                     input logic eb, input logic ed, input logic er);
    vec_t v;
    v.lv = lv; v.ip = ip; v.ss = ss; v.rot = rot; v.si = si;
    v.eo = eo; v.es = es; v.eb = eb; v.ed = ed; v.er = er;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    load_valid = 0; in_par = '0; scan_start = 0; rotate = 0; scan_in = '0;
  endtask

  localparam logic [63:0] L  = 64'h4444_3333_2222_1111;
  localparam logic [63:0] P2 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] FF = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int t1, t2, pulses, busy_after, done_seen;

    // lv ip ss rot si | out_par scan_out busy done ready
    add(1, L,  0, 0, 16'h0000, L,                     16'h4444, 0, 0, 1);
    add(0, 0,  1, 0, 16'h0000, L,                     16'h4444, 1, 0, 0);
    add(0, 0,  0, 0, 16'hA0A0, 64'h3333_2222_1111_A0A0, 16'h3333, 1, 0, 0);
    add(0, 0,  0, 0, 16'hB0B0, 64'h2222_1111_A0A0_B0B0, 16'h2222, 1, 0, 0);
    add(0, 0,  0, 0, 16'hC0C0, 64'h1111_A0A0_B0B0_C0C0, 16'h1111, 1, 0, 0);
    add(0, 0,  0, 0, 16'hD0D0, 64'hA0A0_B0B0_C0C0_D0D0, 16'hA0A0, 0, 1, 1);
    add(0, 0,  0, 0, 16'h0000, 64'hA0A0_B0B0_C0C0_D0D0, 16'hA0A0, 0, 0, 1);
    add(1, P2, 1, 0, 16'h0000, P2,                    16'h0123, 0, 0, 1);
    add(0, 0,  0, 0, 16'h0000, P2,                    16'h0123, 0, 0, 1);
    add(0, 0,  1, 1, 16'h0000, P2,                    16'h0123, 1, 0, 0);
    add(1, FF, 1, 0, 16'hDEAD, 64'h4567_89AB_CDEF_0123, 16'h4567, 1, 0, 0);
    add(1, FF, 1, 0, 16'hBEEF, 64'h89AB_CDEF_0123_4567, 16'h89AB, 1, 0, 0);
    add(1, FF, 1, 0, 16'h1357, 64'hCDEF_0123_4567_89AB, 16'hCDEF, 1, 0, 0);
    add(1, FF, 0, 0, 16'h2468, P2,                    16'h0123, 0, 1, 1);
    add(0, 0,  0, 0, 16'h0000, P2,                    16'h0123, 0, 0, 1);

    idle_inputs();
    u1_load_valid = 0; u1_in_par = '0; u1_scan_start = 0; u1_rotate = 0; u1_scan_in = '0;
    rst_n = 0;
    step();
    step();
    chk("rst_out_par", out_par, 0);
    chk("rst_scan_out", {48'd0, scan_out}, 0);
    chk("rst_busy", {63'd0, busy}, 0);
    chk("rst_done", {63'd0, done}, 0);
    chk("rst_ready", {63'd0, load_ready}, 1);
    rst_n = 1;
    step();

    foreach (vecs[i]) begin
      load_valid = vecs[i].lv; in_par = vecs[i].ip; scan_start = vecs[i].ss;
      rotate = vecs[i].rot; scan_in = vecs[i].si;
      step();
      chk($sformatf("v%0d_out_par", i), out_par, vecs[i].eo);
      chk($sformatf("v%0d_scan_out", i), {48'd0, scan_out}, {48'd0, vecs[i].es});
      chk($sformatf("v%0d_busy", i), {63'd0, busy}, {63'd0, vecs[i].eb});
      chk($sformatf("v%0d_done", i), {63'd0, done}, {63'd0, vecs[i].ed});
      chk($sformatf("v%0d_ready", i), {63'd0, load_ready}, {63'd0, vecs[i].er});
    end
    idle_inputs();

    // Rotation with random scan_in restores the loaded contents.
    load_valid = 1; in_par = L;
    step();
    load_valid = 0; scan_start = 1; rotate = 1;
    step();
    scan_start = 0; rotate = 0;
    for (int i = 0; i < 4; i++) begin
      scan_in = 16'($urandom);
      step();
    end
    chk("rot_restore", out_par, L);
    chk("rot_done", {63'd0, done}, 1);
    idle_inputs();
    step();

    // Back-to-back scans: restart in the DONE cycle.
    load_valid = 1; in_par = L;
    step();
    load_valid = 0; scan_start = 1; scan_in = 16'h5555;
    step();
    scan_start = 0;
    pulses = 0; t1 = 0; t2 = 0; busy_after = 0;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (pulses == 1 && i == t1 + 1) busy_after = busy;
      if (done) begin
        pulses++;
        if (pulses == 1) begin
          t1 = i; scan_start = 1; scan_in = 16'h6666;
        end else begin
          t2 = i;
        end
      end else begin
        scan_start = 0;
      end
    end
    chk("b2b_pulses", 64'(pulses), 2);
    chk("b2b_first", 64'(t1), 4);
    chk("b2b_gap", 64'(t2 - t1), 5);
    chk("b2b_busy", 64'(busy_after), 1);
    chk("b2b_data", out_par, 64'h6666_6666_6666_6666);
    idle_inputs();

    // Reset in the middle of a scan aborts it.
    load_valid = 1; in_par = L;
    step();
    load_valid = 0; scan_start = 1; scan_in = 16'h7777;
    step();
    scan_start = 0;
    step();
    rst_n = 0;
    step();
    step();
    chk("mrst_out_par", out_par, 0);
    chk("mrst_busy", {63'd0, busy}, 0);
    chk("mrst_done", {63'd0, done}, 0);
    chk("mrst_ready", {63'd0, load_ready}, 1);
    rst_n = 1;
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) done_seen = 1;
    end
    chk("mrst_no_done", 64'(done_seen), 0);
    chk("mrst_data", out_par, 0);

    // depth=1 build: one-cycle SHIFT, rotate leaves data alone.
    u1_load_valid = 1; u1_in_par = 16'h1111;
    step();
    chk("d1_load", {48'd0, u1_out_par}, 64'h1111);
    u1_load_valid = 0; u1_scan_start = 1; u1_rotate = 0; u1_scan_in = 16'hA0A0;
    step();
    chk("d1_busy", {63'd0, u1_busy}, 1);
    chk("d1_hold", {48'd0, u1_scan_out}, 64'h1111);
    u1_scan_start = 0;
    step();
    chk("d1_shift", {48'd0, u1_out_par}, 64'hA0A0);
    chk("d1_done", {63'd0, u1_done}, 1);
    chk("d1_busy_off", {63'd0, u1_busy}, 0);
    u1_scan_start = 1; u1_rotate = 1; u1_scan_in = 16'hFFFF;
    step();
    u1_scan_start = 0;
    step();
    chk("d1_rot", {48'd0, u1_out_par}, 64'hA0A0);
    chk("d1_rot_done", {63'd0, u1_done}, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/msk_scan_chain.md
# msk_scan_chain

Multi-stage masked scan register chain: `depth` stages, each holding `count` masked bits of `d` shares. Supports a parallel load of all stages and a controller-sequenced serial scan of exactly `depth` shifts, either open (external `scan_in` enters, stage `depth-1` exits) or circular (rotation that restores the original contents). It generalises the single masked scan register with mux and enable into a counted, handshaked chain. It is used for state/key reload and share-domain readout paths around the masked AES core.

## Interface
Parameters:
- `d`, 2, number of shares per bit.
- `count`, 8, masked bits per stage.
- `depth`, 4, number of stages (≥1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `load_valid`  in  1  parallel-load request.
- `load_ready`  out  1  parallel load accepted when `load_valid & load_ready`.
- `in_par`  in  depth*count*d  parallel-load data; stage k at bits [(k+1)*count*d-1 : k*count*d].
- `scan_start`  in  1  starts a `depth`-shift scan sequence.
- `rotate`  in  1  sampled with `scan_start`: 1 = circular, 0 = open scan.
- `scan_in`  in  count*d  data entering stage 0 on each open-scan shift.
- `scan_out`  out  count*d  stage `depth-1` contents.
- `out_par`  out  depth*count*d  all stage contents, same layout as `in_par`.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse after the last shift.

Share layout within a stage: bit i, share j at index i*d+j.

## Operation
- FSM states: IDLE, SHIFT, DONE.
  - IDLE/DONE → SHIFT on `scan_start`, unless a load is accepted in the same cycle. `rotate` latches into `rot_q`; shift counter clears to 0.
  - SHIFT: one shift per cycle. Stage k ← stage k-1 for k≥1. Stage 0 ← `scan_in`, or ← stage `depth-1` when `rot_q`=1. Counter increments.
  - SHIFT → DONE after the shift with counter = `depth-1`.
  - DONE → IDLE unconditionally, unless a new scan starts.
- Output decodes:
  - `busy` = (state==SHIFT).
  - `done` = (state==DONE).
  - `load_ready` = (state!=SHIFT).
- Parallel load in IDLE or DONE: all stages ← `in_par` on the accepting edge.
- Load has priority over `scan_start` in the same cycle. The start is dropped, not queued.
- During SHIFT:
  - `load_valid` is ignored (`load_ready`=0).
  - `scan_start` and `rotate` are ignored.
- Outside load/shift, stages hold their value.
- Counter width: $clog2(depth), minimum 1 bit.
- depth=1: SHIFT lasts exactly one cycle. Rotate is then a no-op on data.
- Shares are moved only, never recombined. No logic mixes shares of one bit.

## Timing
- Reset (`rst_n`=0 at an edge) gives:
  - state IDLE; all stages 0 (valid sharing of 0);
  - `busy`=0, `done`=0, `load_ready`=1, `scan_out`=0, `out_par`=0.
- Reset mid-SHIFT aborts the scan: no `done`, data cleared.
- Load latency 1: accepted at edge t → `out_par` = `in_par` from t.
- Scan: `scan_start` accepted at edge t.
  - `busy`=1 for cycles t..t+depth-1.
  - Shifts occur at edges t+1..t+depth. `scan_in` is sampled at each of those edges.
  - `done`=1 during cycle t+depth. A new `scan_start` in that cycle begins the next SHIFT with no idle gap.
- `scan_out` is registered (direct stage output). First open-scan exit word = pre-scan stage `depth-1`.

## Structure
- Shared package `msk_scan_pkg`:
  - FSM state encoding localparams (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - counter-width function.
- Natural sub-module `msk_scan_stage`, one per stage, instantiated via generate. It contains:
  - 3-way masked select (hold / parallel / shift input);
  - masked enable register with synchronous zero reset.
- The top holds the FSM, counter, rotate latch and stage wiring.
- Keep-hierarchy on `msk_scan_stage` so share-separation can be checked per stage.

## Test plan
All scenarios use d=2, count=8, depth=4.
1. **Reset:** drive `rst_n`=0 for 2 cycles during SHIFT → `out_par`=0, `busy`=0, `done`=0, `load_ready`=1, no `done` pulse afterwards.
2. **Load:** load stages {0x1111,0x2222,0x3333,0x4444} → `out_par` matches next cycle; `scan_out`=0x4444.
3. **Open scan:** after load, `scan_start` with `rotate`=0, `scan_in` = 0xA0A0,0xB0B0,0xC0C0,0xD0D0 → `scan_out` sequence 0x4444,0x3333,0x2222,0x1111. Final stages {0xD0D0,0xC0C0,0xB0B0,0xA0A0}. `done` pulses exactly 4 cycles after start.
4. **Rotate:** after load, start with `rotate`=1, `scan_in` random → contents equal the original load after 4 shifts; `scan_in` has no effect.
5. **Collision and blocking:**
   - `load_valid` and `scan_start` in the same IDLE cycle → load taken, `busy` stays 0.
   - `load_valid` held during SHIFT → `load_ready`=0, data unaffected.
6. **Back-to-back:** `scan_start` during the DONE cycle → `busy`=1 next cycle, two `done` pulses 5 cycles apart; depth=1 build repeats scenario 3 with 1-cycle SHIFT.
